// File: rtl/rv32i.sv
// Shared RV32I constants and types for the fetch front end.
package rv32i;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [INST_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry holding buffer that catches a
// fetch response arriving while the decoder is stalled.
module if_id_reg
  import rv32i::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  resp_valid,
  input  logic [INST_WIDTH-1:0] resp_instr,
  input  logic [XLEN-1:0]       resp_pc,
  output logic                  buf_full,
  output logic                  ifid_valid,
  output logic [INST_WIDTH-1:0] ifid_instr,
  output logic [XLEN-1:0]       ifid_pc
);

  logic                  valid_q;
  logic [INST_WIDTH-1:0] instr_q;
  logic [XLEN-1:0]       pc_q;
  logic                  buf_valid_q;
  logic [INST_WIDTH-1:0] buf_instr_q;
  logic [XLEN-1:0]       buf_pc_q;

  // Flush beats stall; a buffered entry always drains ahead of a new response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      pc_q        <= '0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      buf_valid_q <= 1'b0;
    end else if (stall) begin
      if (resp_valid) begin
        buf_valid_q <= 1'b1;
        buf_instr_q <= resp_instr;
        buf_pc_q    <= resp_pc;
      end
    end else if (buf_valid_q) begin
      valid_q     <= 1'b1;
      instr_q     <= buf_instr_q;
      pc_q        <= buf_pc_q;
      buf_valid_q <= resp_valid;
      buf_instr_q <= resp_instr;
      buf_pc_q    <= resp_pc;
    end else if (resp_valid) begin
      valid_q <= 1'b1;
      instr_q <= resp_instr;
      pc_q    <= resp_pc;
    end else begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end
  end

  assign buf_full   = buf_valid_q;
  assign ifid_valid = valid_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, request FSM (one outstanding fetch) and the
// IF/ID register with stall buffering and redirect flushing.
module if_stage
  import rv32i::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [XLEN-1:0]       imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [XLEN-1:0]       redirect_pc_i,
  output logic                  ifid_valid_o,
  output logic [INST_WIDTH-1:0] ifid_instr_o,
  output logic [XLEN-1:0]       ifid_pc_o,
  output logic [XLEN-1:0]       ifid_pc4_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic            resp_accept;
  logic            buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= word_align(RESET_PC);
      req_pc_q <= word_align(RESET_PC);
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    resp_accept = 1'b0;

    case (state_q)
      IDLE: begin
        if (!(stall_i && buf_full)) state_d = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          state_d  = WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          drop_d      = 1'b0;
          resp_accept = !drop_q;
          if (drop_q || (!stall_i && !buf_full)) state_d = REQ;
          else                                   state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fetch still in flight after a redirect must be drained and discarded
    // before the new target may be requested.
    if (redirect_i) begin
      pc_d        = word_align(redirect_pc_i);
      resp_accept = 1'b0;
      if ((state_q == WAIT && !imem_rvalid) || (state_q == REQ && imem_gnt)) begin
        state_d = WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = REQ;
        drop_d  = 1'b0;
      end
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_i),
    .stall      (stall_i),
    .resp_valid (resp_accept),
    .resp_instr (imem_rdata),
    .resp_pc    (req_pc_q),
    .buf_full   (buf_full),
    .ifid_valid (ifid_valid_o),
    .ifid_instr (ifid_instr_o),
    .ifid_pc    (ifid_pc_o)
  );

  assign ifid_pc4_o = ifid_pc_o + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// Randomised and directed bench for if_stage: a memory responder feeds the
// DUT, and a monitor compares consumed instructions against program order.
module tb_if_stage;
  import rv32i::*;

  localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o, ifid_pc_o, ifid_pc4_o;

  logic        req2, gnt2, rvalid2, stall2, redirect2;
  logic [31:0] addr2, rdata2, redirect_pc2;
  logic        ifid_valid2;
  logic [31:0] ifid_instr2, ifid_pc2, ifid_pc4_2;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          consumed = 0;
  int          gnt_lat  = 0;
  int          rv_lat   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  logic [31:0] addr2_q[$];
  bit          seen2 = 0;
  logic [31:0] first_pc2, first_pc4_2, first_instr2;

  if_stage #(.RESET_PC(RESET_PC_A)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .ifid_valid_o(ifid_valid_o), .ifid_instr_o(ifid_instr_o),
    .ifid_pc_o(ifid_pc_o), .ifid_pc4_o(ifid_pc4_o)
  );

  if_stage #(.RESET_PC(RESET_PC_B)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .stall_i(stall2), .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
    .ifid_valid_o(ifid_valid2), .ifid_instr_o(ifid_instr2),
    .ifid_pc_o(ifid_pc2), .ifid_pc4_o(ifid_pc4_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h0000_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_bit(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endfunction

  function automatic void fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
  endfunction

  function automatic void restart_stream(input logic [31:0] a);
    exp_q.delete();
    next_pc = {a[31:2], 2'b00};
    fill();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    fill();
  endtask

  task automatic wait_fresh_req(input string name);
    int n = 0;
    while (imem_req && n < 30) begin step(); n++; end
    while (!imem_req && n < 30) begin step(); n++; end
    if (!imem_req) fail_now(name);
  endtask

  // Memory model for the main DUT: grant/response latencies set by gnt_lat
  // and rv_lat (negative = random), never more than one fetch pending.
  initial begin
    bit          s_req, s_rst, pending;
    logic [31:0] s_addr, paddr;
    int          pdelay, age, gwait;
    pending = 0; age = 0; gwait = 0; pdelay = 0; paddr = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      s_req = imem_req; s_addr = imem_addr; s_rst = rst_n;
      @(posedge clk);
      #1;
      if (imem_rvalid) pending = 0;
      if (imem_gnt && s_req && s_rst) begin
        pending = 1;
        paddr   = s_addr;
        pdelay  = (rv_lat < 0) ? int'($urandom_range(0, 3)) : rv_lat;
      end
      if (pending && pdelay == 0) begin
        imem_rvalid = 1;
        imem_rdata  = mem_word(paddr);
      end else begin
        imem_rvalid = 0;
        imem_rdata  = $urandom;
        if (pending) pdelay--;
      end
      if (imem_req && !pending) begin
        if (age == 0) gwait = (gnt_lat < 0) ? int'($urandom_range(0, 3)) : gnt_lat;
        imem_gnt = (age >= gwait);
        age++;
      end else begin
        imem_gnt = 0;
        age      = 0;
      end
    end
  end

  // Zero-wait memory for the wrap-around instance.
  initial begin
    bit          s_req;
    logic [31:0] s_addr;
    gnt2 = 0; rvalid2 = 0; rdata2 = '0;
    stall2 = 0; redirect2 = 0; redirect_pc2 = '0;
    forever begin
      @(negedge clk);
      s_req = req2; s_addr = addr2;
      @(posedge clk);
      #1;
      rvalid2 = gnt2 && s_req && rst_n;
      rdata2  = rvalid2 ? mem_word(s_addr) : 32'h0;
      if (rvalid2) addr2_q.push_back(s_addr);
      gnt2 = req2;
      if (ifid_valid2 && !seen2) begin
        seen2        = 1;
        first_pc2    = ifid_pc2;
        first_pc4_2  = ifid_pc4_2;
        first_instr2 = ifid_instr2;
      end
    end
  end

  // Monitor: an instruction is consumed when valid and neither stalled nor
  // flushed; it must be the next address of the current program stream.
  initial begin
    bit          p_ok, p_req, p_gnt, p_redir;
    logic [31:0] p_addr, e;
    p_ok = 0; p_req = 0; p_gnt = 0; p_redir = 0; p_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_ok = 0;
      end else begin
        check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        if (!ifid_valid_o) check("bubble_nop", ifid_instr_o, NOP_INSTR);
        if (p_ok && p_req && !p_gnt && !p_redir) begin
          check_bit("req_held", imem_req, 1'b1);
          check("addr_held", imem_addr, p_addr);
        end
        if (ifid_valid_o && !stall_i && !redirect_i) begin
          consumed++;
          if (exp_q.size() == 0) begin
            fail_now("stream_underflow");
          end else begin
            e = exp_q.pop_front();
            check("ifid_pc", ifid_pc_o, e);
            check("ifid_instr", ifid_instr_o, mem_word(e));
            check("ifid_pc4", ifid_pc4_o, e + 32'd4);
          end
        end
        p_ok = 1; p_req = imem_req; p_gnt = imem_gnt;
        p_redir = redirect_i; p_addr = imem_addr;
      end
    end
  end

  initial begin
    int          n;
    int          c0;
    logic [31:0] a0, tgt;
    rst_n = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
    restart_stream(RESET_PC_A);
    repeat (2) @(posedge clk);
    #3;
    check_bit("rst_req", imem_req, 1'b0);
    check_bit("rst_valid", ifid_valid_o, 1'b0);
    check("rst_instr", ifid_instr_o, NOP_INSTR);
    check("rst_pc", ifid_pc_o, 32'h0);
    check_bit("rst_req_b", req2, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // First fetch latency and sequential addresses.
    wait_fresh_req("first_req");
    check("first_addr", imem_addr, RESET_PC_A);
    step(); step();
    check_bit("lat_valid", ifid_valid_o, 1'b1);
    check("lat_pc", ifid_pc_o, 32'h0);
    check_bit("second_req", imem_req, 1'b1);
    check("second_addr", imem_addr, 32'h4);
    wait_fresh_req("third_req");
    check("third_addr", imem_addr, 32'h8);

    // Wrap-around instance.
    if (addr2_q.size() < 2) fail_now("wrap_fetches");
    else begin
      check("wrap_first_addr", addr2_q[0], RESET_PC_B);
      check("wrap_second_addr", addr2_q[1], 32'h0);
    end
    check_bit("wrap_seen", seen2, 1'b1);
    check("wrap_first_pc", first_pc2, RESET_PC_B);
    check("wrap_first_pc4", first_pc4_2, 32'h0);
    check("wrap_first_instr", first_instr2, mem_word(RESET_PC_B));

    // Stall across the return of the 0x93 fetch.
    check("pre_stall_pc", ifid_pc_o, 32'h4);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit("stall_hold_valid", ifid_valid_o, 1'b1);
      check("stall_hold_pc", ifid_pc_o, 32'h4);
      if (i > 0) check_bit("stall_no_req", imem_req, 1'b0);
    end
    stall_i = 0;
    step();
    check_bit("unstall_valid", ifid_valid_o, 1'b1);
    check("unstall_pc", ifid_pc_o, 32'h8);
    check("unstall_instr", ifid_instr_o, 32'h0000_0093);
    check_bit("unstall_req", imem_req, 1'b1);
    check("unstall_addr", imem_addr, 32'hC);

    // Redirect while a fetch is outstanding.
    rv_lat = 3;
    step();
    redirect_i = 1;
    redirect_pc_i = 32'h0000_0102;
    restart_stream(32'h0000_0102);
    gnt_lat = 5;
    step();
    redirect_i = 0;
    check_bit("redir_flush", ifid_valid_o, 1'b0);
    check_bit("redir_wait", imem_req, 1'b0);
    n = 0;
    while (!imem_req && n < 20) begin
      check_bit("redir_bubble", ifid_valid_o, 1'b0);
      step();
      n++;
    end
    if (!imem_req) fail_now("redir_req");
    check("redir_addr", imem_addr, 32'h0000_0100);
    rv_lat = 0;

    // Grant withheld for five cycles.
    a0 = imem_addr;
    for (int i = 0; i < 5; i++) begin
      check_bit("gnt_hold_req", imem_req, 1'b1);
      check("gnt_hold_addr", imem_addr, a0);
      step();
    end
    gnt_lat = 0;

    // Reset pulse during WAIT.
    rv_lat = 3;
    n = 0;
    while (!imem_gnt && n < 20) begin step(); n++; end
    step();
    #2;
    rst_n = 0;
    #1;
    check_bit("async_req", imem_req, 1'b0);
    check_bit("async_valid", ifid_valid_o, 1'b0);
    check("async_instr", ifid_instr_o, NOP_INSTR);
    check("async_pc", ifid_pc_o, 32'h0);
    restart_stream(RESET_PC_A);
    rv_lat = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    wait_fresh_req("rst_restart_req");
    check("rst_restart_addr", imem_addr, RESET_PC_A);
    n = 0;
    while (!ifid_valid_o && n < 20) begin step(); n++; end
    check_bit("rst_restart_valid", ifid_valid_o, 1'b1);
    check("rst_restart_pc", ifid_pc_o, RESET_PC_A);
    check("rst_restart_instr", ifid_instr_o, mem_word(RESET_PC_A));

    // Random traffic with stalls, redirects and variable memory latency.
    gnt_lat = -1;
    rv_lat  = -1;
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      if (i == 100 || $urandom_range(0, 39) == 0) begin
        tgt = (i == 100) ? 32'hFFFF_FFF0 : $urandom;
        redirect_i    = 1;
        redirect_pc_i = tgt;
        restart_stream(tgt);
      end else begin
        redirect_i = 0;
      end
      step();
    end
    stall_i = 0;
    redirect_i = 0;
    repeat (20) step();
    check_bit("random_progress", (consumed - c0) > 150, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
